serial_addsub_multidigit: RTL and testbench

//  Serial adder/subtractor. Operands arrive LSB-digit first, DIGIT_W bits per valid beat.

---
 rtl/serial_addsub_multidigit.sv | 151 +++++++++++++++
 tb/tb_serial_addsub_multidigit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_multidigit.sv
// -----------------------------------------------------------------------------
// serial_addsub_multidigit
//
// Serial adder/subtractor working DIGIT_W bits per valid beat, least
// significant digit first. Each beat yields a combinational result digit on
// `sum`. The digits are also collected into a result word. That word is
// presented, together with carry-out, signed overflow, beat count and a
// truncation flag, in the cycle after the beat that carries `last`.
//
// Ports
//   clk      in   1        clock
//   rst      in   1        synchronous reset, active-high
//   vld      in   1        a/b/sub/last valid this cycle
//   a        in   DIGIT_W  operand A digit
//   b        in   DIGIT_W  operand B digit
//   sub      in   1        1 = A-B, taken from the first beat of an op
//   last     in   1        final digit of the op (only meaningful with vld)
//   sum      out  DIGIT_W  per-beat result digit, 0 when vld=0
//   res_vld  out  1        one-cycle pulse: res/cout/ovf/len/trunc updated
//   res      out  RES_W    assembled result, LSB digit at [DIGIT_W-1:0]
//   cout     out  1        final carry (subtract: 1 = no borrow)
//   ovf      out  1        signed overflow at the final digit MSB
//   len      out  LEN_W    beats in the op, saturating at MAX_BEATS
//   trunc    out  1        op had more than MAX_BEATS beats
// -----------------------------------------------------------------------------
module serial_addsub_multidigit #(
    parameter  int DIGIT_W   = 1,
    parameter  int MAX_BEATS = 8,
    localparam int RES_W     = DIGIT_W * MAX_BEATS,
    localparam int LEN_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               sub,
    input  logic               last,
    output logic [DIGIT_W-1:0] sum,
    output logic               res_vld,
    output logic [RES_W-1:0]   res,
    output logic               cout,
    output logic               ovf,
    output logic [LEN_W-1:0]   len,
    output logic               trunc
);

    // Op-in-progress state
    logic               r_carry;
    logic [LEN_W-1:0]   r_beat_cnt;
    logic               r_sub_q;
    logic [RES_W-1:0]   r_acc;
    logic               r_trunc_q;

    // Result registers
    logic               r_res_vld;
    logic [RES_W-1:0]   r_res;
    logic               r_cout;
    logic               r_ovf;
    logic [LEN_W-1:0]   r_len;
    logic               r_trunc;

    logic               w_first;
    logic               w_s_eff;
    logic               w_cin;
    logic [DIGIT_W-1:0] w_b_eff;
    logic [DIGIT_W:0]   w_full;
    logic [DIGIT_W-1:0] w_d;
    logic               w_c_out;
    logic               w_c_msb;
    logic               w_room;
    logic [LEN_W-1:0]   w_cnt_next;
    logic [RES_W-1:0]   w_acc_next;

    // A beat counter of zero marks the first beat. After saturation the
    // counter stays at MAX_BEATS, so it never falls back to zero mid-op.
    assign w_first = (r_beat_cnt == '0);
    assign w_s_eff = w_first ? sub : r_sub_q;
    assign w_cin   = w_first ? sub : r_carry;
    assign w_b_eff = b ^ {DIGIT_W{w_s_eff}};
    assign w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, w_cin};
    assign w_d     = w_full[DIGIT_W-1:0];
    assign w_c_out = w_full[DIGIT_W];

    // Carry into the digit MSB, recovered from the MSB sum bit and its inputs.
    assign w_c_msb = w_d[DIGIT_W-1] ^ a[DIGIT_W-1] ^ w_b_eff[DIGIT_W-1];

    assign w_room     = (r_beat_cnt < LEN_W'(MAX_BEATS));
    assign w_cnt_next = w_room ? (r_beat_cnt + LEN_W'(1)) : r_beat_cnt;

    // Insert the current digit into its slot. Once the counter has saturated
    // no slot matches, so the accumulator holds.
    generate
        for (genvar gi = 0; gi < MAX_BEATS; gi++) begin : g_acc_slot
            assign w_acc_next[gi*DIGIT_W +: DIGIT_W] =
                (r_beat_cnt == LEN_W'(gi)) ? w_d : r_acc[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    assign sum = vld ? w_d : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry    <= 1'b0;
            r_beat_cnt <= '0;
            r_sub_q    <= 1'b0;
            r_acc      <= '0;
            r_trunc_q  <= 1'b0;
            r_res_vld  <= 1'b0;
            r_res      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_len      <= '0;
            r_trunc    <= 1'b0;
        end else begin
            r_res_vld <= 1'b0;
            if (vld) begin
                if (last) begin
                    r_res_vld  <= 1'b1;
                    r_res      <= w_acc_next;
                    r_cout     <= w_c_out;
                    r_ovf      <= w_c_msb ^ w_c_out;
                    r_len      <= w_cnt_next;
                    r_trunc    <= r_trunc_q | ~w_room;
                    // Return to idle so a first beat may follow immediately
                    r_carry    <= 1'b0;
                    r_beat_cnt <= '0;
                    r_sub_q    <= 1'b0;
                    r_acc      <= '0;
                    r_trunc_q  <= 1'b0;
                end else begin
                    r_carry    <= w_c_out;
                    r_acc      <= w_acc_next;
                    r_beat_cnt <= w_cnt_next;
                    r_trunc_q  <= r_trunc_q | ~w_room;
                    if (w_first) begin
                        r_sub_q <= sub;
                    end
                end
            end
        end
    end

    assign res_vld = r_res_vld;
    assign res     = r_res;
    assign cout    = r_cout;
    assign ovf     = r_ovf;
    assign len     = r_len;
    assign trunc   = r_trunc;

endmodule

// File: tb/tb_serial_addsub_multidigit.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_multidigit
//
// Directed bench for two configurations: DIGIT_W=1/MAX_BEATS=8 (instance 1)
// and DIGIT_W=4/MAX_BEATS=2 (instance 2). The expected result of each op is
// computed from whole-word arithmetic and queued when the op is driven. It is
// popped and compared when the DUT pulses res_vld.
// -----------------------------------------------------------------------------
module tb_serial_addsub_multidigit;

    typedef struct {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        logic [3:0] len;
        logic       trunc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       vld1, sub1, last1;
    logic [0:0] a1, b1, sum1;
    logic       res_vld1, cout1, ovf1, trunc1;
    logic [7:0] res1;
    logic [3:0] len1;

    logic       vld2, sub2, last2;
    logic [3:0] a2, b2, sum2;
    logic       res_vld2, cout2, ovf2, trunc2;
    logic [7:0] res2;
    logic [1:0] len2;

    int checks = 0;
    int errors = 0;
    exp_t q1[$];
    exp_t q2[$];

    initial forever #5 clk = ~clk;

    serial_addsub_multidigit #(.DIGIT_W(1), .MAX_BEATS(8)) u_dut1 (
        .clk(clk), .rst(rst), .vld(vld1), .a(a1), .b(b1), .sub(sub1),
        .last(last1), .sum(sum1), .res_vld(res_vld1), .res(res1),
        .cout(cout1), .ovf(ovf1), .len(len1), .trunc(trunc1)
    );

    serial_addsub_multidigit #(.DIGIT_W(4), .MAX_BEATS(2)) u_dut2 (
        .clk(clk), .rst(rst), .vld(vld2), .a(a2), .b(b2), .sub(sub2),
        .last(last2), .sum(sum2), .res_vld(res_vld2), .res(res2),
        .cout(cout2), .ovf(ovf2), .len(len2), .trunc(trunc2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: n digits of w bits, A +/- B.
    function automatic logic [63:0] calc_full(input logic [63:0] A, input logic [63:0] B,
                                              input int n, input int w, input bit s);
        logic [63:0] mask, be;
        mask = (64'd1 << (n*w)) - 64'd1;
        be   = s ? (~B & mask) : (B & mask);
        return (A & mask) + be + 64'(s);
    endfunction

    function automatic exp_t make_exp(input logic [63:0] A, input logic [63:0] B,
                                      input int n, input int w, input int mx, input bit s);
        exp_t e;
        logic [63:0] mask, be, full;
        int nb, l;
        nb   = n * w;
        mask = (64'd1 << nb) - 64'd1;
        be   = s ? (~B & mask) : (B & mask);
        full = calc_full(A, B, n, w, s);
        l    = (n < mx) ? n : mx;
        e.res   = 8'(full & ((64'd1 << (l*w)) - 64'd1));
        e.cout  = full[nb];
        e.ovf   = (A[nb-1] == be[nb-1]) && (full[nb-1] != A[nb-1]);
        e.len   = 4'(l);
        e.trunc = (n > mx);
        return e;
    endfunction

    // Called just after each falling edge: consumes any result pulse.
    task automatic monitor();
        exp_t e;
        if (res_vld1) begin
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("res1",   64'(res1),   64'(e.res));
                chk("cout1",  64'(cout1),  64'(e.cout));
                chk("ovf1",   64'(ovf1),   64'(e.ovf));
                chk("len1",   64'(len1),   64'(e.len));
                chk("trunc1", 64'(trunc1), 64'(e.trunc));
                $display("inst1 result res=%0h cout=%0b ovf=%0b len=%0d trunc=%0b",
                         res1, cout1, ovf1, len1, trunc1);
            end else begin
                chk("res_vld1_unexpected", 64'(res_vld1), 64'd0);
            end
        end
        if (res_vld2) begin
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("res2",   64'(res2),   64'(e.res));
                chk("cout2",  64'(cout2),  64'(e.cout));
                chk("ovf2",   64'(ovf2),   64'(e.ovf));
                chk("len2",   64'(len2),   64'(e.len));
                chk("trunc2", 64'(trunc2), 64'(e.trunc));
                $display("inst2 result res=%0h cout=%0b ovf=%0b len=%0d trunc=%0b",
                         res2, cout2, ovf2, len2, trunc2);
            end else begin
                chk("res_vld2_unexpected", 64'(res_vld2), 64'd0);
            end
        end
    endtask

    task automatic drive(input int inst, input logic v, input logic [3:0] x,
                         input logic [3:0] y, input logic s, input logic l);
        if (inst == 1) begin
            vld1 = v; a1 = x[0]; b1 = y[0]; sub1 = s; last1 = l;
        end else begin
            vld2 = v; a2 = x; b2 = y; sub2 = s; last2 = l;
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            monitor();
            drive(1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
            drive(2, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        end
    endtask

    // Drive one op; optional vld=0 gaps between beats carry last=1 and junk data.
    task automatic run_op(input int inst, input logic [63:0] A, input logic [63:0] B,
                          input int n, input bit s, input int gap);
        int w, mx;
        logic [63:0] full, dmask, sobs;
        w  = (inst == 1) ? 1 : 4;
        mx = (inst == 1) ? 8 : 2;
        full  = calc_full(A, B, n, w, s);
        dmask = (64'd1 << w) - 64'd1;
        if (inst == 1) q1.push_back(make_exp(A, B, n, w, mx, s));
        else           q2.push_back(make_exp(A, B, n, w, mx, s));
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            monitor();
            // sub is inverted after the first beat: it must be ignored there
            drive(inst, 1'b1, 4'((A >> (k*w)) & dmask), 4'((B >> (k*w)) & dmask),
                  (k == 0) ? s : ~s, (k == n-1));
            #1;
            sobs = (inst == 1) ? 64'(sum1) : 64'(sum2);
            chk((inst == 1) ? "sum1" : "sum2", sobs, (full >> (k*w)) & dmask);
            $display("inst%0d beat %0d sum=%0h", inst, k, sobs);
            if (k < n-1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    monitor();
                    drive(inst, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
                    #1;
                    sobs = (inst == 1) ? 64'(sum1) : 64'(sum2);
                    chk("sum_gap", sobs, 64'd0);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        drive(2, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_res_vld1", 64'(res_vld1), 64'd0);
        chk("rst_res1",     64'(res1),     64'd0);
        chk("rst_cout1",    64'(cout1),    64'd0);
        chk("rst_ovf1",     64'(ovf1),     64'd0);
        chk("rst_len1",     64'(len1),     64'd0);
        chk("rst_trunc1",   64'(trunc1),   64'd0);
        chk("rst_sum1",     64'(sum1),     64'd0);
        chk("rst_res2",     64'(res2),     64'd0);
        chk("rst_sum2",     64'(sum2),     64'd0);
        rst = 1'b0;

        // Add 3+5, then two subtracts back to back
        run_op(1, 64'd3, 64'd5, 4, 1'b0, 0);
        run_op(1, 64'd5, 64'd3, 4, 1'b1, 0);
        run_op(1, 64'd3, 64'd5, 4, 1'b1, 0);
        idle(2);

        // Same add with gaps carrying a stray last
        run_op(1, 64'd3, 64'd5, 4, 1'b0, 2);
        idle(2);

        // Wide digits: 0xFF+0x01, then back-to-back single beat 7+1
        run_op(2, 64'hFF, 64'h01, 2, 1'b0, 0);
        run_op(2, 64'h7, 64'h1, 1, 1'b0, 0);
        run_op(2, 64'h123, 64'h045, 3, 1'b1, 0);
        idle(2);

        // 10-beat all-ones add, truncated at 8 beats
        run_op(1, 64'h3FF, 64'h3FF, 10, 1'b0, 0);
        idle(2);

        // Abort an op with reset; reset wins over a simultaneous last beat
        @(negedge clk); monitor(); drive(1, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
        @(negedge clk); monitor(); drive(1, 1'b1, 4'h1, 4'h0, 1'b0, 1'b0);
        @(negedge clk); monitor(); rst = 1'b1; drive(1, 1'b1, 4'h1, 4'h1, 1'b0, 1'b1);
        @(negedge clk); monitor();
        chk("abort_res_vld1", 64'(res_vld1), 64'd0);
        chk("abort_res1",     64'(res1),     64'd0);
        chk("abort_len1",     64'(len1),     64'd0);
        chk("abort_trunc1",   64'(trunc1),   64'd0);
        chk("abort_cout1",    64'(cout1),    64'd0);
        rst = 1'b0;
        drive(1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        run_op(1, 64'd3, 64'd5, 4, 1'b0, 0);
        idle(3);

        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
